// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction-fetch sequencer. Issues one fetch request at a time from the
// current PC, waits for the memory response, holds the fetched instruction
// for the decode stage until it is accepted, then advances the PC by four.
// Redirects (branch/jump/resume) replace the PC at any point. A misaligned
// redirect target diverts to TRAP_VECTOR and raises a one-cycle trap pulse.
// A halt request, honoured only at the moment an instruction retires,
// parks the sequencer until the next redirect.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-low reset
//   imem_req_valid   fetch request valid
//   imem_req_addr    fetch address (always equal to pc)
//   imem_req_ready   memory accepts the request
//   imem_rsp_valid   fetch data valid (single-cycle pulse)
//   imem_rsp_data    fetched instruction word
//   instr_valid      instruction presented to decode
//   instr            presented instruction
//   instr_pc         address of presented instruction
//   core_ready       decode accepts the presented instruction
//   redirect_valid   single-cycle redirect request
//   redirect_addr    redirect target
//   halt             stop fetching once the current instruction retires
//   pc               current fetch PC
//   trap             one-cycle pulse on misaligned redirect
//   retired_count    number of accepted instructions (wraps)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        core_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        trap,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAIT_RSP = 2'd1,
        HOLD     = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic [31:0] instr_pc_r;
    logic [31:0] instr_pc_s;
    logic [31:0] count_r;
    logic [31:0] count_s;
    logic        squash_r;
    logic        squash_s;
    logic        trap_r;
    logic        trap_s;
    logic        req_valid_r;
    logic        instr_valid_r;
    logic        misaligned_s;
    logic [31:0] target_s;
    logic        handshake_s;

    // Redirect target decode and decode-stage handshake detection.
    always_comb begin
        misaligned_s = 1'b0;
        target_s     = redirect_addr;
        if (redirect_addr[1:0] != 2'b00) begin
            misaligned_s = 1'b1;
            target_s     = TRAP_VECTOR;
        end else begin
            misaligned_s = 1'b0;
            target_s     = redirect_addr;
        end
        handshake_s = instr_valid_r & core_ready;
    end

    // Next-state and datapath update logic for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        count_s    = count_r;
        squash_s   = squash_r;
        trap_s     = redirect_valid & misaligned_s;

        case (state_r)
            REQ: begin
                if (redirect_valid) begin
                    pc_s = target_s;
                    if (imem_req_ready) begin
                        // Memory took the old address; its response must be dropped.
                        state_s  = WAIT_RSP;
                        squash_s = 1'b1;
                    end else begin
                        state_s = REQ;
                    end
                end else if (imem_req_ready) begin
                    state_s = WAIT_RSP;
                end else begin
                    state_s = REQ;
                end
            end

            WAIT_RSP: begin
                if (redirect_valid) begin
                    pc_s = target_s;
                    if (imem_rsp_valid) begin
                        // The outstanding response lands now and is discarded here.
                        squash_s = 1'b0;
                        state_s  = REQ;
                    end else begin
                        squash_s = 1'b1;
                        state_s  = WAIT_RSP;
                    end
                end else if (imem_rsp_valid) begin
                    if (squash_r) begin
                        squash_s = 1'b0;
                        state_s  = REQ;
                    end else begin
                        instr_s    = imem_rsp_data;
                        instr_pc_s = pc_r;
                        state_s    = HOLD;
                    end
                end else begin
                    state_s = WAIT_RSP;
                end
            end

            HOLD: begin
                // Retirement counts even when a redirect lands in the same cycle.
                if (handshake_s) begin
                    count_s = count_r + 32'd1;
                end else begin
                    count_s = count_r;
                end
                if (redirect_valid) begin
                    pc_s    = target_s;
                    state_s = REQ;
                end else if (handshake_s) begin
                    pc_s = pc_r + 32'd4;
                    if (halt) begin
                        state_s = HALTED;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = HOLD;
                end
            end

            HALTED: begin
                if (redirect_valid) begin
                    pc_s    = target_s;
                    state_s = REQ;
                end else begin
                    state_s = HALTED;
                end
            end

            default: begin
                state_s  = REQ;
                squash_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; output strobes are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= REQ;
            pc_r          <= RESET_VECTOR;
            instr_r       <= 32'd0;
            instr_pc_r    <= 32'd0;
            count_r       <= 32'd0;
            squash_r      <= 1'b0;
            trap_r        <= 1'b0;
            req_valid_r   <= 1'b1;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            count_r       <= count_s;
            squash_r      <= squash_s;
            trap_r        <= trap_s;
            req_valid_r   <= (state_s == REQ);
            instr_valid_r <= (state_s == HOLD);
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign pc             = pc_r;
    assign trap           = trap_r;
    assign retired_count  = count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. A memory model answers fetches with
// a deterministic function of the address. An architectural reference model
// keeps the queue of the next instruction address the core must see: it
// advances by four on each retirement, is replaced by the redirect target (or
// the trap vector) on every redirect, and empties when halt retires. A monitor
// pops that queue on every decode handshake and compares.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0004;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        core_ready;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] retired_count;

    pc_sequencer #(
        .RESET_VECTOR (RST_VEC),
        .TRAP_VECTOR  (TRAP_VEC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .core_ready     (core_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .pc             (pc),
        .trap           (trap),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_hs  = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic        hs_pending = 1'b0;
    logic [31:0] hs_pc      = 32'd0;
    logic [31:0] m_count    = 32'd0;
    logic        m_trap     = 1'b0;
    logic        m_halted   = 1'b0;
    logic [31:0] m_halt_pc  = 32'd0;
    logic [31:0] m_tgt;

    // Memory model state
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [31:0] mem_addr = 32'd0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: updates expectations at each clock edge from the bench's own stimulus.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            exp_q.push_back(RST_VEC);
            m_count  = 32'd0;
            m_trap   = 1'b0;
            m_halted = 1'b0;
        end else begin
            m_trap = 1'b0;
            if (hs_pending) begin
                m_count = m_count + 32'd1;
                n_hs++;
            end
            if (redirect_valid) begin
                m_tgt  = redirect_addr;
                m_trap = (m_tgt[1:0] != 2'b00);
                if (m_trap) m_tgt = TRAP_VEC;
                exp_q.delete();
                exp_q.push_back(m_tgt);
                m_halted = 1'b0;
            end else if (hs_pending) begin
                if (halt) begin
                    m_halted  = 1'b1;
                    m_halt_pc = hs_pc + 32'd4;
                end else begin
                    exp_q.push_back(hs_pc + 32'd4);
                end
            end
        end
        hs_pending = 1'b0;
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("retired_count", retired_count, m_count);
            chk("trap", {31'd0, trap}, {31'd0, m_trap});
            if (m_halted) begin
                chk("halted_req_valid", {31'd0, imem_req_valid}, 32'd0);
                chk("halted_instr_valid", {31'd0, instr_valid}, 32'd0);
                chk("halted_pc", pc, m_halt_pc);
            end else if (exp_q.size() == 0) begin
                chk("expect_queue_nonempty", 32'd0, 32'd1);
            end else begin
                chk("pc", pc, exp_q[0]);
                if (imem_req_valid) chk("req_addr", imem_req_addr, exp_q[0]);
                if (instr_valid) begin
                    chk("req_valid_in_hold", {31'd0, imem_req_valid}, 32'd0);
                    chk("instr_pc", instr_pc, exp_q[0]);
                    chk("instr", instr, mem_fn(exp_q[0]));
                    if (core_ready) begin
                        hs_pc      = exp_q.pop_front();
                        hs_pending = 1'b1;
                    end
                end
            end
        end
    end

    // One clock cycle: apply inputs, let the edge happen, then run the memory model.
    task automatic step(input logic r, input logic rdy, input logic cr,
                        input logic rv, input logic [31:0] ra, input logic h);
        logic        acc;
        logic [31:0] acc_addr;
        rst            = r;
        imem_req_ready = rdy;
        core_ready     = cr;
        redirect_valid = rv;
        redirect_addr  = ra;
        halt           = h;
        @(negedge clk);
        acc      = rst & imem_req_valid & imem_req_ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            mem_cnt  = mem_lat;
            mem_addr = acc_addr;
        end
        if (mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mem_addr);
            mem_cnt        = 0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (mem_cnt > 0) mem_cnt--;
        end
    endtask

    task automatic normal_step();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    // mode 0: waiting for a response; mode 1: instruction presented
    function automatic logic cond(input int mode);
        if (mode == 0) return (imem_req_valid === 1'b0) && (instr_valid === 1'b0) && !m_halted;
        else return (instr_valid === 1'b1);
    endfunction

    task automatic run_until(input int mode, input int max_cyc);
        int k;
        k = 0;
        while (!cond(mode) && k < max_cyc) begin
            normal_step();
            k++;
        end
        chk($sformatf("reach_mode_%0d", mode), {31'd0, cond(mode)}, 32'd1);
    endtask

    task automatic run_retire(input int n, input int max_cyc);
        logic [31:0] goal;
        int k;
        goal = m_count + n;
        k = 0;
        while (m_count != goal && k < max_cyc) begin
            normal_step();
            k++;
        end
        chk("retire_progress", m_count, goal);
    endtask

    initial begin
        logic        rv;
        logic [31:0] ra;
        int          sel;
        logic [31:0] base;

        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        core_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'd0;
        halt           = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("rst_pc", pc, RST_VEC);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_retired", retired_count, 32'd0);

        // Straight-line fetch of 0x0, 0x4, 0x8
        mem_lat = 1;
        run_retire(3, 40);
        chk("retired_after_three", retired_count, 32'd3);

        // Redirect while a response is outstanding
        mem_lat = 3;
        run_until(0, 20);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        chk("redirect_pc", pc, 32'h0000_0100);
        run_retire(1, 30);

        // Misaligned redirect
        mem_lat = 1;
        run_until(1, 20);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
        chk("trap_pulse_high", {31'd0, trap}, 32'd1);
        normal_step();
        chk("trap_pulse_low", {31'd0, trap}, 32'd0);
        chk("trap_fetch_pc", pc, TRAP_VEC);
        run_retire(1, 30);

        // Decode stall for five cycles
        run_until(1, 20);
        base = m_count;
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("stall_retired", retired_count, base);
        run_retire(1, 30);

        // Halt at retirement, then resume via redirect
        run_until(1, 20);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        repeat (6) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'($urandom_range(0, 1)));
        chk("halted_no_req", {31'd0, imem_req_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("resume_pc", pc, 32'h0000_0200);
        run_retire(1, 30);

        // PC wrap from 0xFFFFFFFC to 0
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_retire(2, 40);

        // Reset mid-fetch; stale response arrives while in REQ
        mem_lat = 3;
        run_until(0, 20);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("midreset_pc", pc, RST_VEC);
        chk("midreset_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("midreset_retired", retired_count, 32'd0);
        mem_lat = 1;
        run_retire(1, 30);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            mem_lat = $urandom_range(1, 3);
            rv  = ($urandom_range(0, 99) < 5);
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            if (sel == 0) begin
                ra[1:0] = 2'($urandom_range(1, 3));
            end else if (sel == 1) begin
                ra = 32'hFFFF_FFFC;
            end else begin
                ra[1:0] = 2'b00;
            end
            step(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), rv, ra,
                 ($urandom_range(0, 99) < 8));
        end
        chk("random_activity", {31'd0, (n_hs >= 100)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
